fmlbrg_tagctl: RTL and testbench
================================

# fmlbrg_tagctl

Cache tag controller for the FML bridge: sits between the bridge's request front-end and the synchronous-read tag RAM, and owns all accesses to that RAM. Per request it reads the tag for the index, decides hit or miss, sequences dirty-line eviction and line refill toward the FML side, then writes back the updated tag entry. After reset it sweeps the RAM to invalidate every entry.

## Interface
Parameters:
- depth, 2: index bits; RAM holds 2^depth entries.
- width, 20: address tag bits; RAM entry width is width+2 as {valid, dirty, tag}.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req_stb  in  1  request valid; held until req_ack.
- req_we  in  1  request is a write (marks line dirty).
- req_tag  in  width  address tag of request.
- req_idx  in  depth  cache index of request.
- req_ack  out  1  one-cycle completion pulse; line is resident.
- busy  out  1  controller not in IDLE.
- tm_a  out  depth  tag RAM address.
- tm_we  out  1  tag RAM write enable.
- tm_di  out  width+2  tag RAM write data.
- tm_do  in  width+2  tag RAM read data; valid the cycle after tm_a is presented.
- evict_stb  out  1  write-back of dirty line requested.
- evict_adr  out  width+depth  {victim tag, index}.
- evict_ack  in  1  write-back complete.
- refill_stb  out  1  line fill requested.
- refill_adr  out  width+depth  {req tag, index}.
- refill_ack  in  1  fill complete.
- flush_req  in  1  pulse: write back and invalidate all lines.
- flush_done  out  1  one-cycle pulse when flush finishes.

## Operation
- States: INIT, IDLE, LOOKUP, EVICT, REFILL, UPDATE, FLUSH_RD, FLUSH_CHK, FLUSH_EVICT.
- Reset: state INIT, walker index 0; req_ack, tm_we, evict_stb, refill_stb, flush_done 0; busy 1; tm_a, tm_di, evict_adr, refill_adr 0.
- INIT: tm_we=1, tm_di=0, tm_a=walker; increment per cycle; after entry 2^depth-1 go IDLE.
- IDLE: when req_stb=1, latch req_we/tag/idx, drive tm_a=req_idx, go LOOKUP. flush_req (if enabled) has priority over req_stb when both are asserted in the same cycle.
- LOOKUP: hit = valid & tag==req_tag.
  - Hit and (read, or write with dirty already set): req_ack, go IDLE.
  - Hit and write, clean: go UPDATE.
  - Miss and victim valid&dirty: latch victim tag, go EVICT.
  - Miss otherwise: go REFILL.
- EVICT: evict_stb held high with evict_adr stable until the evict_ack cycle, then REFILL.
- REFILL: refill_stb held high with refill_adr stable until the refill_ack cycle, then UPDATE.
- UPDATE: tm_we=1, tm_di={1, req_we | (hit & old dirty), req_tag}; req_ack; go IDLE.
- A strobe with no ack stalls indefinitely. An ack arriving while its strobe is low is ignored.
- Reset asserted mid-operation: strobes drop asynchronously, and the INIT sweep restarts from index 0.

## Timing
- Acceptance at cycle 0 (IDLE, req_stb=1).
- Read hit: req_ack at cycle 1 (LOOKUP, combinational from tm_do). Clean write hit: req_ack at cycle 2.
- Clean miss: refill_stb from cycle 2; req_ack in the cycle after refill_ack.
- Dirty miss: evict_stb from cycle 2; refill_stb in the cycle after evict_ack.
- INIT lasts exactly 2^depth cycles after reset release.
- req_stb must stay high through req_ack. The next request may be accepted in the cycle after req_ack.

## Configuration
- FMLBRG_TAGCTL_FLUSH_EN defined:
  - flush_req in IDLE starts a walk over all indexes via FLUSH_RD (drive tm_a), FLUSH_CHK, then FLUSH_EVICT if the entry is valid&dirty.
  - Each visited index is written to 0.
  - flush_done pulses after the last index, then the controller returns to IDLE.
- Undefined: flush_req ignored; flush_done tied 0; FLUSH_* states absent.

## Structure
- Package fmlbrg_pkg holds:
  - the state enum;
  - localparams for entry bit positions (VALID = width+1, DIRTY = width);
  - the entry field extract helpers.
- Sub-module fmlbrg_tagctl_walker: the index counter with a last-index flag, shared by INIT and FLUSH.

## Test plan
- Reset release, depth=2 -> tm_we=1 for 4 cycles, tm_a 0,1,2,3, tm_di=0; busy falls on cycle 4.
- Read idx 1 tag 0x5 on empty cache -> refill_stb, refill_adr=0x15; ack after 3 cycles -> UPDATE writes {1,0,0x5}, then req_ack.
- Repeat the same read -> req_ack at cycle 1 with no strobes.
- Write idx 1 tag 0x5, then read idx 1 tag 0x9 -> evict_adr=0x15, then refill_adr=0x25, final entry {1,0,0x9}.
- Reset asserted while refill_stb is high -> strobe drops immediately; INIT sweep restarts from 0.
- FLUSH_EN with two dirty lines -> exactly two evicts, all entries 0, a single flush_done pulse.

Source files
------------

// File: rtl/fmlbrg_pkg.sv
// fmlbrg_pkg: shared types and tag-entry helpers for the FML bridge tag controller.
// Entry layout is {valid, dirty, tag}; VALID sits at bit width+1, DIRTY at bit width.
// FLUSH_* states exist only when FMLBRG_TAGCTL_FLUSH_EN is defined.
package fmlbrg_pkg;

  // Default tag width and the entry bit positions that go with it
  localparam int unsigned TAG_W = 20;
  localparam int unsigned VALID = TAG_W + 1;
  localparam int unsigned DIRTY = TAG_W;

  // Helpers work on a zero-extended entry so any tag width up to 62 fits
  localparam int unsigned ENTRY_MAX_W = 64;
  typedef logic [ENTRY_MAX_W-1:0] entry_max_t;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    LOOKUP,
    EVICT,
    REFILL,
    UPDATE
`ifdef FMLBRG_TAGCTL_FLUSH_EN
    ,
    FLUSH_RD,
    FLUSH_CHK,
    FLUSH_EVICT
`endif
  } state_e;

  function automatic logic entry_valid(entry_max_t e, int unsigned width);
    entry_max_t sh;
    sh = e >> (width + 1);
    return sh[0];
  endfunction

  function automatic logic entry_dirty(entry_max_t e, int unsigned width);
    entry_max_t sh;
    sh = e >> width;
    return sh[0];
  endfunction

  function automatic entry_max_t entry_tag(entry_max_t e, int unsigned width);
    return e & ((entry_max_t'(1) << width) - entry_max_t'(1));
  endfunction

endpackage

// File: rtl/fmlbrg_tagctl_walker.sv
// fmlbrg_tagctl_walker: index counter with last-index flag, shared by the
// post-reset invalidate sweep and the flush walk. Wraps to 0 after the last index.
module fmlbrg_tagctl_walker #(
  parameter int unsigned depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [depth-1:0] idx,
  output logic             last
);

  logic [depth-1:0] idx_q, idx_d;

  // Next index: clear wins over increment
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = &idx_q;

endmodule

// File: rtl/fmlbrg_tagctl.sv
// fmlbrg_tagctl: cache tag controller for the FML bridge. Owns the synchronous
// tag RAM: invalidate sweep after reset, lookup, dirty eviction, refill, tag update.
// Optional flush walk enabled by defining FMLBRG_TAGCTL_FLUSH_EN.
module fmlbrg_tagctl
  import fmlbrg_pkg::*;
#(
  parameter int unsigned depth = 2,
  parameter int unsigned width = TAG_W
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   req_stb,
  input  logic                   req_we,
  input  logic [width-1:0]       req_tag,
  input  logic [depth-1:0]       req_idx,
  output logic                   req_ack,
  output logic                   busy,
  output logic [depth-1:0]       tm_a,
  output logic                   tm_we,
  output logic [width+1:0]       tm_di,
  input  logic [width+1:0]       tm_do,
  output logic                   evict_stb,
  output logic [width+depth-1:0] evict_adr,
  input  logic                   evict_ack,
  output logic                   refill_stb,
  output logic [width+depth-1:0] refill_adr,
  input  logic                   refill_ack,
  input  logic                   flush_req,
  output logic                   flush_done
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [width-1:0] tag_q, tag_d;
  logic [depth-1:0] idx_q, idx_d;
  logic [width-1:0] victim_q, victim_d;
  logic             hit_q, hit_d;
  logic             odirty_q, odirty_d;

  logic             walk_clr, walk_inc, walk_last;
  logic [depth-1:0] walk_idx;
  logic [depth-1:0] evict_idx;

  logic             ent_valid, ent_dirty, hit;
  logic [width-1:0] ent_tag;

  fmlbrg_tagctl_walker #(
    .depth(depth)
  ) u_walker (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .clr  (walk_clr),
    .inc  (walk_inc),
    .idx  (walk_idx),
    .last (walk_last)
  );

  // Decode the entry returned by the RAM for the address presented last cycle
  always_comb begin
    ent_valid = entry_valid(entry_max_t'(tm_do), width);
    ent_dirty = entry_dirty(entry_max_t'(tm_do), width);
    ent_tag   = width'(entry_tag(entry_max_t'(tm_do), width));
    hit       = ent_valid && (ent_tag == tag_q);
  end

  // Next-state and outputs; outputs are forced low while reset is held so the
  // INIT sweep writes nothing until reset is released
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    victim_d   = victim_q;
    hit_d      = hit_q;
    odirty_d   = odirty_q;
    walk_clr   = 1'b0;
    walk_inc   = 1'b0;
    req_ack    = 1'b0;
    tm_we      = 1'b0;
    tm_a       = idx_q;
    tm_di      = '0;
    evict_stb  = 1'b0;
    refill_stb = 1'b0;
    flush_done = 1'b0;

    case (state_q)
      INIT: begin
        tm_we    = 1'b1;
        tm_a     = walk_idx;
        walk_inc = 1'b1;
        if (walk_last) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        tm_a = req_idx;
`ifdef FMLBRG_TAGCTL_FLUSH_EN
        if (flush_req) begin
          walk_clr = 1'b1;
          state_d  = FLUSH_RD;
        end else
`endif
        if (req_stb) begin
          we_d    = req_we;
          tag_d   = req_tag;
          idx_d   = req_idx;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        hit_d    = hit;
        odirty_d = ent_dirty;
        if (hit) begin
          if (!we_q || ent_dirty) begin
            req_ack = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = UPDATE;
          end
        end else if (ent_valid && ent_dirty) begin
          victim_d = ent_tag;
          state_d  = EVICT;
        end else begin
          state_d = REFILL;
        end
      end

      EVICT: begin
        evict_stb = 1'b1;
        if (evict_ack) begin
          state_d = REFILL;
        end
      end

      REFILL: begin
        refill_stb = 1'b1;
        if (refill_ack) begin
          state_d = UPDATE;
        end
      end

      UPDATE: begin
        tm_we   = 1'b1;
        tm_di   = {1'b1, we_q | (hit_q & odirty_q), tag_q};
        req_ack = 1'b1;
        state_d = IDLE;
      end

`ifdef FMLBRG_TAGCTL_FLUSH_EN
      FLUSH_RD: begin
        tm_a    = walk_idx;
        state_d = FLUSH_CHK;
      end

      FLUSH_CHK: begin
        tm_a = walk_idx;
        if (ent_valid && ent_dirty) begin
          victim_d = ent_tag;
          state_d  = FLUSH_EVICT;
        end else begin
          tm_we    = 1'b1;
          walk_inc = 1'b1;
          if (walk_last) begin
            flush_done = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = FLUSH_RD;
          end
        end
      end

      FLUSH_EVICT: begin
        tm_a      = walk_idx;
        evict_stb = 1'b1;
        if (evict_ack) begin
          tm_we    = 1'b1;
          walk_inc = 1'b1;
          if (walk_last) begin
            flush_done = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = FLUSH_RD;
          end
        end
      end
`endif

      default: begin
        state_d = INIT;
      end
    endcase

    if (!sys_rst_n) begin
      req_ack    = 1'b0;
      tm_we      = 1'b0;
      tm_a       = '0;
      tm_di      = '0;
      evict_stb  = 1'b0;
      refill_stb = 1'b0;
      flush_done = 1'b0;
    end
  end

  // State and request/victim registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= INIT;
      we_q     <= 1'b0;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= '0;
      hit_q    <= 1'b0;
      odirty_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      hit_q    <= hit_d;
      odirty_q <= odirty_d;
    end
  end

`ifdef FMLBRG_TAGCTL_FLUSH_EN
  assign evict_idx = (state_q == FLUSH_EVICT) ? walk_idx : idx_q;
`else
  assign evict_idx = idx_q;
  logic unused_flush_req;
  assign unused_flush_req = flush_req;
`endif

  assign busy       = (state_q != IDLE);
  assign evict_adr  = {victim_q, evict_idx};
  assign refill_adr = {tag_q, idx_q};

endmodule

// File: tb/tb_fmlbrg_tagctl.sv
// tb_fmlbrg_tagctl: directed self-checking bench for fmlbrg_tagctl (depth=2, width=20)
// with a behavioural synchronous-read tag RAM. Flush checks follow FMLBRG_TAGCTL_FLUSH_EN.
module tb_fmlbrg_tagctl;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned WIDTH = 20;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               req_stb = 1'b0;
  logic               req_we = 1'b0;
  logic [WIDTH-1:0]   req_tag = '0;
  logic [DEPTH-1:0]   req_idx = '0;
  logic               req_ack;
  logic               busy;
  logic [DEPTH-1:0]   tm_a;
  logic               tm_we;
  logic [WIDTH+1:0]   tm_di;
  logic [WIDTH+1:0]   tm_do = '0;
  logic               evict_stb;
  logic [WIDTH+DEPTH-1:0] evict_adr;
  logic               evict_ack = 1'b0;
  logic               refill_stb;
  logic [WIDTH+DEPTH-1:0] refill_adr;
  logic               refill_ack = 1'b0;
  logic               flush_req = 1'b0;
  logic               flush_done;

  logic [WIDTH+1:0]   mem [4];

  int checks = 0;
  int errors = 0;

  fmlbrg_tagctl #(
    .depth(DEPTH),
    .width(WIDTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_stb   (req_stb),
    .req_we    (req_we),
    .req_tag   (req_tag),
    .req_idx   (req_idx),
    .req_ack   (req_ack),
    .busy      (busy),
    .tm_a      (tm_a),
    .tm_we     (tm_we),
    .tm_di     (tm_di),
    .tm_do     (tm_do),
    .evict_stb (evict_stb),
    .evict_adr (evict_adr),
    .evict_ack (evict_ack),
    .refill_stb(refill_stb),
    .refill_adr(refill_adr),
    .refill_ack(refill_ack),
    .flush_req (flush_req),
    .flush_done(flush_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous-read tag RAM, read-before-write
  always @(posedge sys_clk) begin
    if (tm_we) mem[tm_a] <= tm_di;
    tm_do <= mem[tm_a];
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where reset has just been released
  task automatic init_sweep;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_eq("init_we", 64'(tm_we), 64'd1);
      chk_eq("init_a", 64'(tm_a), 64'(i));
      chk_eq("init_di", 64'(tm_di), 64'd0);
      chk_eq("init_busy", 64'(busy), 64'd1);
      @(negedge sys_clk);
    end
    chk_eq("init_end_busy", 64'(busy), 64'd0);
    chk_eq("init_end_we", 64'(tm_we), 64'd0);
  endtask

  // Run one request to completion, acking strobes in the cycle they are seen
  task automatic do_req(input logic we, input logic [WIDTH-1:0] tag, input logic [DEPTH-1:0] idx);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    req_stb = 1'b1; req_we = we; req_tag = tag; req_idx = idx;
    while (!done && n < 50) begin
      @(negedge sys_clk);
      n++;
      evict_ack = evict_stb;
      refill_ack = refill_stb;
      if (req_ack) done = 1'b1;
    end
    req_stb = 1'b0; evict_ack = 1'b0; refill_ack = 1'b0;
    chk_eq("req_done", 64'(done), 64'd1);
  endtask

  initial begin
    // Reset values
    #12;
    chk_eq("rst_ack", 64'(req_ack), 64'd0);
    chk_eq("rst_we", 64'(tm_we), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd1);
    chk_eq("rst_evict", 64'(evict_stb), 64'd0);
    chk_eq("rst_refill", 64'(refill_stb), 64'd0);
    chk_eq("rst_a", 64'(tm_a), 64'd0);
    chk_eq("rst_evadr", 64'(evict_adr), 64'd0);
    chk_eq("rst_rfadr", 64'(refill_adr), 64'd0);
    chk_eq("rst_fdone", 64'(flush_done), 64'd0);

    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    init_sweep();

    // Read miss on empty cache, refill acked in its third cycle
    req_stb = 1'b1; req_we = 1'b0; req_tag = 20'h5; req_idx = 2'd1;
    #1 chk_eq("c0_tm_a", 64'(tm_a), 64'd1);
    @(negedge sys_clk);
    chk_eq("miss_c1_ack", 64'(req_ack), 64'd0);
    chk_eq("miss_c1_rf", 64'(refill_stb), 64'd0);
    @(negedge sys_clk);
    chk_eq("miss_c2_rf", 64'(refill_stb), 64'd1);
    chk_eq("miss_rfadr", 64'(refill_adr), 64'h15);
    chk_eq("miss_c2_ev", 64'(evict_stb), 64'd0);
    @(negedge sys_clk);
    chk_eq("miss_c3_rf", 64'(refill_stb), 64'd1);
    @(negedge sys_clk);
    chk_eq("miss_c4_rf", 64'(refill_stb), 64'd1);
    refill_ack = 1'b1;
    @(negedge sys_clk);
    refill_ack = 1'b0;
    chk_eq("upd_ack", 64'(req_ack), 64'd1);
    chk_eq("upd_we", 64'(tm_we), 64'd1);
    chk_eq("upd_a", 64'(tm_a), 64'd1);
    chk_eq("upd_di", 64'(tm_di), 64'h200005);
    chk_eq("upd_rf", 64'(refill_stb), 64'd0);
    req_stb = 1'b0;
    @(negedge sys_clk);
    chk_eq("idle_busy", 64'(busy), 64'd0);
    chk_eq("mem1_a", 64'(mem[1]), 64'h200005);

    // Same read: hit, ack in cycle 1, no strobes
    req_stb = 1'b1; req_we = 1'b0; req_tag = 20'h5; req_idx = 2'd1;
    @(negedge sys_clk);
    chk_eq("hit_ack", 64'(req_ack), 64'd1);
    chk_eq("hit_ev", 64'(evict_stb), 64'd0);
    chk_eq("hit_rf", 64'(refill_stb), 64'd0);
    chk_eq("hit_we", 64'(tm_we), 64'd0);
    req_stb = 1'b0;
    @(negedge sys_clk);
    chk_eq("hit_idle", 64'(busy), 64'd0);

    // Clean write hit: ack in cycle 2 with dirty set
    req_stb = 1'b1; req_we = 1'b1; req_tag = 20'h5; req_idx = 2'd1;
    @(negedge sys_clk);
    chk_eq("wh_c1_ack", 64'(req_ack), 64'd0);
    @(negedge sys_clk);
    chk_eq("wh_c2_ack", 64'(req_ack), 64'd1);
    chk_eq("wh_di", 64'(tm_di), 64'h300005);
    chk_eq("wh_we", 64'(tm_we), 64'd1);
    req_stb = 1'b0;
    @(negedge sys_clk);

    // Dirty miss: evict (stalled one cycle, stray refill_ack ignored), then refill
    req_stb = 1'b1; req_we = 1'b0; req_tag = 20'h9; req_idx = 2'd1;
    @(negedge sys_clk);
    chk_eq("dm_c1_ack", 64'(req_ack), 64'd0);
    chk_eq("dm_c1_ev", 64'(evict_stb), 64'd0);
    @(negedge sys_clk);
    chk_eq("dm_c2_ev", 64'(evict_stb), 64'd1);
    chk_eq("dm_evadr", 64'(evict_adr), 64'h15);
    chk_eq("dm_c2_rf", 64'(refill_stb), 64'd0);
    refill_ack = 1'b1;
    @(negedge sys_clk);
    chk_eq("dm_c3_ev", 64'(evict_stb), 64'd1);
    chk_eq("dm_c3_rf", 64'(refill_stb), 64'd0);
    chk_eq("dm_c3_evadr", 64'(evict_adr), 64'h15);
    refill_ack = 1'b0;
    evict_ack = 1'b1;
    @(negedge sys_clk);
    evict_ack = 1'b0;
    chk_eq("dm_c4_ev", 64'(evict_stb), 64'd0);
    chk_eq("dm_c4_rf", 64'(refill_stb), 64'd1);
    chk_eq("dm_rfadr", 64'(refill_adr), 64'h25);
    refill_ack = 1'b1;
    @(negedge sys_clk);
    refill_ack = 1'b0;
    chk_eq("dm_ack", 64'(req_ack), 64'd1);
    chk_eq("dm_di", 64'(tm_di), 64'h200009);
    req_stb = 1'b0;
    @(negedge sys_clk);
    chk_eq("mem1_b", 64'(mem[1]), 64'h200009);

    // Write misses on clean lines: refilled entries come back dirty
    do_req(1'b1, 20'h3, 2'd2);
    @(negedge sys_clk);
    chk_eq("mem2", 64'(mem[2]), 64'h300003);
    do_req(1'b1, 20'hA, 2'd0);
    @(negedge sys_clk);
    chk_eq("mem0", 64'(mem[0]), 64'h30000A);

`ifdef FMLBRG_TAGCTL_FLUSH_EN
    begin
      int n_ev;
      int n_done;
      logic [WIDTH+DEPTH-1:0] ev_adr [2];
      n_ev = 0;
      n_done = 0;
      ev_adr[0] = '0;
      ev_adr[1] = '0;
      flush_req = 1'b1;
      @(negedge sys_clk);
      flush_req = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (evict_stb && !evict_ack) begin
          if (n_ev < 2) ev_adr[n_ev] = evict_adr;
          n_ev++;
          evict_ack = 1'b1;
        end else begin
          evict_ack = 1'b0;
        end
        if (flush_done) n_done++;
        @(negedge sys_clk);
      end
      evict_ack = 1'b0;
      chk_eq("fl_evicts", 64'(n_ev), 64'd2);
      chk_eq("fl_ev0", 64'(ev_adr[0]), 64'h28);
      chk_eq("fl_ev1", 64'(ev_adr[1]), 64'h0E);
      chk_eq("fl_done_cnt", 64'(n_done), 64'd1);
      chk_eq("fl_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 4; i++) chk_eq("fl_mem", 64'(mem[i]), 64'd0);
    end
`else
    flush_req = 1'b1;
    @(negedge sys_clk);
    flush_req = 1'b0;
    chk_eq("nofl_busy", 64'(busy), 64'd0);
    chk_eq("nofl_done", 64'(flush_done), 64'd0);
    @(negedge sys_clk);
    chk_eq("nofl_mem0", 64'(mem[0]), 64'h30000A);
`endif

    // Reset while refill_stb is high
    req_stb = 1'b1; req_we = 1'b0; req_tag = 20'h7; req_idx = 2'd3;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk_eq("mr_rf_before", 64'(refill_stb), 64'd1);
    sys_rst_n = 1'b0;
    req_stb = 1'b0;
    #1;
    chk_eq("mr_rf_drop", 64'(refill_stb), 64'd0);
    chk_eq("mr_busy", 64'(busy), 64'd1);
    chk_eq("mr_we", 64'(tm_we), 64'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    init_sweep();
    for (int i = 0; i < 4; i++) chk_eq("mr_mem", 64'(mem[i]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
